// File: rtl/mult_pkg.sv
// Shared types and constants for the two-requester signed multiplier scheduler.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: state enum, operand width N, requester count NREQ, arbitration helpers.
package mult_pkg;

    localparam int N    = 8;
    localparam int NREQ = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADD,
        SHIFT,
        DONE
    } state_t;

    // Round-robin pick between two requesters: a lone requester always wins,
    // on a tie the one that was not served last wins.
    function automatic logic rr_pick(input logic [NREQ-1:0] req, input logic last);
        if (req[0] && req[1]) begin
            return ~last;
        end
        return req[1];
    endfunction

    function automatic logic [NREQ-1:0] req_onehot(input logic idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/shift_add_core.sv
// Signed shift-add multiplier datapath: 9-bit add/sub into {X,A}, 17-bit {X,A,B} shift register.
// Latency: one strobe per step; product appears in {A,B} after the eighth shift.
// Backpressure: none; acts only on the load/add/sub/shift strobes from the scheduler.
// Ports: Clk, Reset (async active-low), load/add/sub/shift strobes, op_a/op_b capture operands,
//        b_lsb (current multiplier bit), prod_nxt ({A,B} as it will be after the next shift).
module shift_add_core
    import mult_pkg::*;
(
    input  logic           Clk,
    input  logic           Reset,
    input  logic           load,
    input  logic           add,
    input  logic           sub,
    input  logic           shift,
    input  logic [N-1:0]   op_a,
    input  logic [N-1:0]   op_b,
    output logic           b_lsb,
    output logic [2*N-1:0] prod_nxt
);

    logic         x;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] s;
    logic [N:0]   sum;

    // Last partial product carries weight -2^7 in two's complement, so it
    // is subtracted instead of added. {x,a} is always a valid sign extension
    // of a at the time an add/sub happens (it follows a shift or a clear).
    assign sum = sub ? ({x, a} - {s[N-1], s}) : ({x, a} + {s[N-1], s});

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            x <= 1'b0;
            a <= '0;
            b <= '0;
            s <= '0;
        end else if (load) begin
            s <= op_a;
            b <= op_b;
            x <= 1'b0;
            a <= '0;
        end else if (add || sub) begin
            {x, a} <= sum;
        end else if (shift) begin
            // Arithmetic right shift of the 17-bit {x,a,b}: x replicates.
            {x, a, b} <= {x, x, a, b[N-1:1]};
        end
    end

    assign b_lsb    = b[0];
    assign prod_nxt = {x, a, b[N-1:1]};

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one 8x8 signed shift-add multiplier between two requesters.
// Latency: Grant one cycle after capture, Done exactly 17 cycles after Grant.
// Backpressure: Req is a level held until Grant; at most one operation in flight.
// Ports: Clk, Reset (async active-low), Req[1:0], OpA0/OpB0/OpA1/OpB1 signed operands,
//        Grant/Done one-hot pulses, Product (last result, held), Busy, Owner (current/last index).
module mult_sched
    import mult_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NREQ-1:0]       Req,
    input  logic signed [N-1:0]   OpA0,
    input  logic signed [N-1:0]   OpB0,
    input  logic signed [N-1:0]   OpA1,
    input  logic signed [N-1:0]   OpB1,
    output logic [NREQ-1:0]       Grant,
    output logic [NREQ-1:0]       Done,
    output logic signed [2*N-1:0] Product,
    output logic                  Busy,
    output logic                  Owner
);

    state_t         state;
    logic [2:0]     cnt;
    logic           last;
    logic           win;
    logic [N-1:0]   cap_a;
    logic [N-1:0]   cap_b;
    logic           ld;
    logic           add;
    logic           sub;
    logic           shift;
    logic           b_lsb;
    logic [2*N-1:0] prod_nxt;

    assign win   = rr_pick(Req, last);
    assign cap_a = win ? OpA1 : OpA0;
    assign cap_b = win ? OpB1 : OpB0;

    assign ld    = (state == IDLE) && (|Req);
    assign add   = (state == ADD) && b_lsb && (cnt != 3'(N-1));
    assign sub   = (state == ADD) && b_lsb && (cnt == 3'(N-1));
    assign shift = (state == SHIFT);

    shift_add_core u_core (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (ld),
        .add      (add),
        .sub      (sub),
        .shift    (shift),
        .op_a     (cap_a),
        .op_b     (cap_b),
        .b_lsb    (b_lsb),
        .prod_nxt (prod_nxt)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            last    <= 1'b1;
            Owner   <= 1'b0;
            Grant   <= '0;
            Done    <= '0;
            Busy    <= 1'b0;
            Product <= '0;
        end else begin
            Grant <= '0;
            Done  <= '0;
            case (state)
                IDLE: begin
                    if (|Req) begin
                        Owner <= win;
                        cnt   <= '0;
                        Grant <= req_onehot(win);
                        Busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state <= ADD;
                end
                ADD: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (cnt == 3'(N-1)) begin
                        // Take the post-shift value so Product is valid
                        // during the Done pulse itself.
                        Product <= prod_nxt;
                        Done    <= req_onehot(Owner);
                        state   <= DONE;
                    end else begin
                        cnt   <= cnt + 3'd1;
                        state <= ADD;
                    end
                end
                DONE: begin
                    last  <= Owner;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
